// File: rtl/comp_swap_lane_array.sv
// comp_swap_lane_array: N_PAIRS independent compare-swap lanes in one registered stage with a skid buffer
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid / in_ready     : input handshake; in_dir selects per-lane order (0 asc, 1 desc)
//   in_a/b_key, in_a/b_pay  : lane i packed at [i*W +: W]
//   out_valid / out_ready   : output handshake
//   out_a/b_key, out_a/b_pay: ordered keys with their payloads; out_swapped flags exchanged lanes
//   cnt_clr, swap_cnt       : synchronous clear and saturating count of lane swaps
module comp_swap_lane_array #(
   parameter int KEY_W   = 16,
   parameter int PAY_W   = 8,
   parameter int N_PAIRS = 4,
   parameter int SIGNED  = 0,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_PAIRS-1:0]         in_dir,
   input  logic [N_PAIRS*KEY_W-1:0]   in_a_key,
   input  logic [N_PAIRS*KEY_W-1:0]   in_b_key,
   input  logic [N_PAIRS*PAY_W-1:0]   in_a_pay,
   input  logic [N_PAIRS*PAY_W-1:0]   in_b_pay,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_PAIRS*KEY_W-1:0]   out_a_key,
   output logic [N_PAIRS*KEY_W-1:0]   out_b_key,
   output logic [N_PAIRS*PAY_W-1:0]   out_a_pay,
   output logic [N_PAIRS*PAY_W-1:0]   out_b_pay,
   output logic [N_PAIRS-1:0]         out_swapped,
   input  logic                       cnt_clr,
   output logic [CNT_W-1:0]           swap_cnt
);
   localparam int AK  = N_PAIRS*KEY_W;
   localparam int AP  = N_PAIRS*PAY_W;
   localparam int WW  = 2*AK + 2*AP + N_PAIRS;
   localparam int PCW = $clog2(N_PAIRS+1);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t state;
   logic [WW-1:0] m, s, nw;
   logic [AK-1:0] na, nb;
   logic [AP-1:0] npa, npb;
   logic [N_PAIRS-1:0] sw;
   logic [PCW-1:0] pc;
   logic [CNT_W:0] sum;
   logic in_fire, out_fire;
   genvar g;
   for (g = 0; g < N_PAIRS; g++) begin : lane
      logic [KEY_W-1:0] a, b;
      logic lt_ba, lt_ab;
      assign a     = in_a_key[g*KEY_W +: KEY_W];
      assign b     = in_b_key[g*KEY_W +: KEY_W];
      assign lt_ba = (SIGNED != 0) ? ($signed(b) < $signed(a)) : (b < a);
      assign lt_ab = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
      // strict compares keep equal keys in place
      assign sw[g] = in_dir[g] ? lt_ab : lt_ba;
      assign na[g*KEY_W +: KEY_W]  = sw[g] ? b : a;
      assign nb[g*KEY_W +: KEY_W]  = sw[g] ? a : b;
      assign npa[g*PAY_W +: PAY_W] = sw[g] ? in_b_pay[g*PAY_W +: PAY_W] : in_a_pay[g*PAY_W +: PAY_W];
      assign npb[g*PAY_W +: PAY_W] = sw[g] ? in_a_pay[g*PAY_W +: PAY_W] : in_b_pay[g*PAY_W +: PAY_W];
   end
   assign nw = {na, nb, npa, npb, sw};
   assign {out_a_key, out_b_key, out_a_pay, out_b_pay, out_swapped} = m;
   assign out_valid = state != EMPTY;
   assign in_ready  = state != FULL;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   always_comb begin
      pc = '0;
      for (int i = 0; i < N_PAIRS; i++) pc = pc + PCW'(sw[i]);
   end
   // one extra bit catches the carry that triggers saturation
   assign sum = {1'b0, swap_cnt} + (CNT_W+1)'(pc);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         m        <= '0;
         s        <= '0;
         swap_cnt <= '0;
      end else begin
         if (cnt_clr) swap_cnt <= '0;
         else if (in_fire) swap_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
         case (state)
            EMPTY: if (in_fire) begin
               m     <= nw;
               state <= ONE;
            end
            ONE: if (in_fire && !out_fire) begin
               s     <= nw;
               state <= FULL;
            end else if (in_fire) m <= nw;
            else if (out_fire) state <= EMPTY;
            FULL: if (out_fire) begin
               m     <= s;
               state <= ONE;
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_comp_swap_lane_array.sv
// tb_comp_swap_lane_array: directed bench for comp_swap_lane_array (unsigned and signed instances)
module tb_comp_swap_lane_array;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, out_ready = 0, cnt_clr = 0;
   logic [3:0] in_dir = '0;
   logic [63:0] in_a_key = '0, in_b_key = '0;
   logic [31:0] in_a_pay = '0, in_b_pay = '0;
   logic in_ready, out_valid;
   logic [63:0] out_a_key, out_b_key;
   logic [31:0] out_a_pay, out_b_pay;
   logic [3:0] out_swapped, swap_cnt;
   logic s_in_ready, s_out_valid;
   logic [63:0] s_out_a_key, s_out_b_key;
   logic [31:0] s_out_a_pay, s_out_b_pay;
   logic [3:0] s_out_swapped, s_swap_cnt;
   int n_cmp = 0, n_err = 0;
   int sent, rcv, occ;
   logic ifire, ofire;
   logic [5:0] pat = 6'b101001;

   always #5 clk = ~clk;

   comp_swap_lane_array #(.KEY_W(16), .PAY_W(8), .N_PAIRS(4), .SIGNED(0), .CNT_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
      .in_a_key(in_a_key), .in_b_key(in_b_key), .in_a_pay(in_a_pay), .in_b_pay(in_b_pay),
      .out_valid(out_valid), .out_ready(out_ready), .out_a_key(out_a_key), .out_b_key(out_b_key),
      .out_a_pay(out_a_pay), .out_b_pay(out_b_pay), .out_swapped(out_swapped),
      .cnt_clr(cnt_clr), .swap_cnt(swap_cnt));

   comp_swap_lane_array #(.KEY_W(16), .PAY_W(8), .N_PAIRS(4), .SIGNED(1), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_dir(in_dir),
      .in_a_key(in_a_key), .in_b_key(in_b_key), .in_a_pay(in_a_pay), .in_b_pay(in_b_pay),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_a_key(s_out_a_key), .out_b_key(s_out_b_key),
      .out_a_pay(s_out_a_pay), .out_b_pay(s_out_b_pay), .out_swapped(s_out_swapped),
      .cnt_clr(cnt_clr), .swap_cnt(s_swap_cnt));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic d, input logic [15:0] ak, input logic [15:0] bk,
                           input logic [7:0] ap, input logic [7:0] bp);
      in_dir[i] = d;
      in_a_key[i*16 +: 16] = ak;
      in_b_key[i*16 +: 16] = bk;
      in_a_pay[i*8 +: 8] = ap;
      in_b_pay[i*8 +: 8] = bp;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_swap_cnt", swap_cnt, 0);
      chk("rst_out_a_key", out_a_key, 0);
      chk("rst_out_swapped", out_swapped, 0);
      rst_n = 1;
      // beat 1: lane0 asc swap, lane1 desc swap, lane2 tie, lane3 ordered
      out_ready = 1;
      in_valid = 1;
      set_lane(0, 0, 16'h0009, 16'h0003, 8'hA1, 8'hB2);
      set_lane(1, 1, 16'h0005, 16'h0007, 8'h51, 8'h72);
      set_lane(2, 0, 16'h1234, 16'h1234, 8'h11, 8'h22);
      set_lane(3, 0, 16'h0001, 16'h0002, 8'h03, 8'h04);
      step();
      chk("b1_out_valid", out_valid, 1);
      chk("b1_l0_a_key", out_a_key[15:0], 16'h0003);
      chk("b1_l0_b_key", out_b_key[15:0], 16'h0009);
      chk("b1_l0_a_pay", out_a_pay[7:0], 8'hB2);
      chk("b1_l0_b_pay", out_b_pay[7:0], 8'hA1);
      chk("b1_l1_a_key", out_a_key[31:16], 16'h0007);
      chk("b1_l1_b_key", out_b_key[31:16], 16'h0005);
      chk("b1_l2_a_key", out_a_key[47:32], 16'h1234);
      chk("b1_l2_a_pay", out_a_pay[23:16], 8'h11);
      chk("b1_l2_b_pay", out_b_pay[23:16], 8'h22);
      chk("b1_l3_a_key", out_a_key[63:48], 16'h0001);
      chk("b1_swapped", out_swapped, 4'b0011);
      chk("b1_swap_cnt", swap_cnt, 2);
      // beat 2: tie with descending dir; lane0 -1 vs 1 distinguishes signed from unsigned
      set_lane(2, 1, 16'h1234, 16'h1234, 8'h11, 8'h22);
      set_lane(0, 0, 16'hFFFF, 16'h0001, 8'hC1, 8'hD2);
      step();
      chk("b2_l2_b_pay", out_b_pay[23:16], 8'h22);
      chk("b2_l0_a_key_u", out_a_key[15:0], 16'h0001);
      chk("b2_swapped_u", out_swapped, 4'b0011);
      chk("b2_l0_a_key_s", s_out_a_key[15:0], 16'hFFFF);
      chk("b2_l0_a_pay_s", s_out_a_pay[7:0], 8'hC1);
      chk("b2_swapped_s", s_out_swapped, 4'b0010);
      chk("b2_swap_cnt", swap_cnt, 4);
      in_valid = 0;
      step();
      chk("drain_out_valid", out_valid, 0);
      // backpressure stream 1..6
      set_lane(0, 0, 16'h0000, 16'hFFFF, 8'h00, 8'h00);
      sent = 0;
      rcv = 0;
      occ = 0;
      for (int c = 0; c < 40 && rcv < 6; c++) begin
         out_ready = (c < 6) ? pat[c] : 1'b1;
         in_valid = sent < 6;
         in_a_key[15:0] = 16'(sent + 1);
         #1;
         ifire = in_valid & in_ready;
         ofire = out_valid & out_ready;
         if (out_valid) chk("bp_order", out_a_key[15:0], 16'(rcv + 1));
         if (ofire) rcv++;
         if (ifire) sent++;
         occ = occ + int'(ifire) - int'(ofire);
         step();
         chk("bp_in_ready", in_ready, occ != 2);
         chk("bp_out_valid", out_valid, occ != 0);
      end
      chk("bp_all_received", rcv, 6);
      in_valid = 0;
      // counter saturation with every lane swapping
      cnt_clr = 1;
      step();
      chk("clr_swap_cnt", swap_cnt, 0);
      cnt_clr = 0;
      out_ready = 1;
      in_valid = 1;
      for (int i = 0; i < 4; i++) set_lane(i, 0, 16'h0002, 16'h0001, 8'h00, 8'h00);
      step();
      chk("cnt_4", swap_cnt, 4);
      step();
      chk("cnt_8", swap_cnt, 8);
      step();
      chk("cnt_12", swap_cnt, 12);
      step();
      chk("cnt_15", swap_cnt, 15);
      step();
      chk("cnt_hold_15", swap_cnt, 15);
      chk("cnt_swapped", out_swapped, 4'b1111);
      cnt_clr = 1;
      step();
      chk("cnt_clr_wins", swap_cnt, 0);
      cnt_clr = 0;
      in_valid = 0;
      step();
      // fill to FULL then reset asynchronously
      out_ready = 0;
      in_valid = 1;
      step();
      step();
      in_valid = 0;
      chk("full_in_ready", in_ready, 0);
      chk("full_swap_cnt", swap_cnt, 8);
      #2;
      rst_n = 0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_swap_cnt", swap_cnt, 0);
      step();
      rst_n = 1;
      out_ready = 1;
      in_valid = 1;
      set_lane(0, 0, 16'h0009, 16'h0003, 8'hA1, 8'hB2);
      step();
      chk("post_rst_out_valid", out_valid, 1);
      chk("post_rst_l0_a_key", out_a_key[15:0], 16'h0003);
      in_valid = 0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/comp_swap_lane_array.md
Name: comp_swap_lane_array

Overview:
- Parametrised successor to the single-pair compare-swap cell.
- Holds N_PAIRS independent compare-swap lanes in one registered pipeline stage.
- Each lane has a runtime direction bit, an optional signed compare and a payload that travels with its key.
- Uses valid/ready flow control with a one-entry skid buffer, so bitonic stages can be chained under backpressure; a saturating swap counter supports profiling.

Parameters:
- KEY_W, 16, key width in bits (compared field).
- PAY_W, 8, payload width per element; carried, never compared. PAY_W >= 1.
- N_PAIRS, 4, number of independent (a,b) lanes.
- SIGNED, 0, 1 = keys compared as two's complement; 0 = unsigned.
- CNT_W, 16, swap counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_dir  in  N_PAIRS  per-lane direction; bit i = 0 ascending (a_o <= b_o), 1 descending (a_o >= b_o)
- in_a_key  in  N_PAIRS*KEY_W  lane i at [i*KEY_W +: KEY_W]
- in_b_key  in  N_PAIRS*KEY_W  same packing
- in_a_pay  in  N_PAIRS*PAY_W  lane i at [i*PAY_W +: PAY_W]
- in_b_pay  in  N_PAIRS*PAY_W  same packing
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_a_key, out_b_key  out  N_PAIRS*KEY_W  ordered keys
- out_a_pay, out_b_pay  out  N_PAIRS*PAY_W  payloads following their keys
- out_swapped  out  N_PAIRS  lane i exchanged its elements
- cnt_clr  in  1  synchronous clear of swap_cnt
- swap_cnt  out  CNT_W  saturating count of lane swaps

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.

Per-lane compare (combinational, ahead of the registers):
- Ascending: swap = (b < a). Descending: swap = (a < b).
- The compare is signed when SIGNED = 1.
- Equal keys never swap, so the stage is stable.
- On swap, key and payload of a and b exchange as a unit; out_swapped[i] = swap.

Storage:
- Main output register (M) and skid register (S), each holding the full result word.
- FSM states: EMPTY (M, S invalid), ONE (M valid), FULL (M and S valid).
- out_valid = state != EMPTY. in_ready = state != FULL (registered, not a function of out_ready).
- EMPTY: input transfer -> M loaded, go to ONE.
- ONE, input transfer with no output transfer -> S loaded, go to FULL.
- ONE, input transfer with output transfer -> M reloaded, stay in ONE.
- ONE, output transfer only -> go to EMPTY.
- FULL: input transfer is impossible. Output transfer -> M <= S, go to ONE.

Latency and ordering:
- Latency is 1 cycle: a beat accepted on edge k is visible on out_* after edge k, when M was empty or draining.
- Throughput is 1 beat/cycle while out_ready = 1.
- Output order equals input order. No beat is dropped or duplicated.
- out_* stay stable while out_valid = 1 and out_ready = 0.

Swap counter:
- On each input transfer, swap_cnt adds popcount(swap), saturating at 2^CNT_W-1 (no wrap).
- If cnt_clr and an input transfer occur in the same cycle, cnt_clr wins: the result is 0 and that beat's swaps are discarded.

Reset (async assert, sync-safe deassert expected upstream):
- state = EMPTY, out_valid = 0, in_ready = 1.
- All out_* data, out_swapped and swap_cnt = 0.
- Reset mid-operation discards M and S contents.

Other rules:
- in_* values are don't-care when in_valid = 0.
- in_dir is sampled with each beat, so direction can change every beat.

Test Plan:
- Ascending swap (N_PAIRS=4, SIGNED=0, dir=0000, out_ready=1): lane0 a=0x0009/pay 0xA1, b=0x0003/pay 0xB2 -> next cycle out_a_key=0x0003 pay 0xB2, out_b_key=0x0009 pay 0xA1, out_swapped[0]=1.
- Descending and ties: dir=1 on lane1, a=5, b=7 -> out a=7, b=5, swapped=1; lane2 a=b=0x1234 with either dir -> unchanged, swapped=0, payloads unswapped.
- Signed compare (SIGNED=1, dir=0): a=0xFFFF (-1), b=0x0001 -> no swap. Same keys with SIGNED=0 -> swap.
- Backpressure: stream beats 1..6 with out_ready toggled 1,0,0,1,0,1,... -> in_ready falls only in FULL; the output sequence is exactly 1..6, and data holds while stalled.
- Counter: every lane swaps on every beat, CNT_W=4 -> swap_cnt goes 4, 8, 12, 15 and holds at 15; cnt_clr asserted with a beat -> 0.
- Reset mid-flight: assert rst_n=0 while in FULL -> out_valid=0, in_ready=1 and swap_cnt=0 immediately (asynchronous); after release, the first beat appears after 1 cycle.
